// File: rtl/rf_arb_pkg.sv
// Shared types and default widths for the register-file access arbiter.
package rf_arb_pkg;

    localparam int DW_DEF    = 16;
    localparam int AW_DEF    = 3;
    localparam int RF_AW_DEF = 8;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick: one-hot grant plus the pointer value to adopt after it.
module rr_arbiter_2
    import rf_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o,
    output logic       ptr_next_o
);

    // A lone requester wins outright; a tie goes to the requester the pointer names.
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (ptr_i == REQ1) ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

    // After a grant the pointer favours the requester that lost.
    always_comb begin
        ptr_next_o = ptr_i;
        if (advance_i && (gnt_o != 2'b00)) begin
            ptr_next_o = gnt_o[0] ? REQ1 : REQ0;
        end else begin
            ptr_next_o = ptr_i;
        end
    end

endmodule

// File: rtl/rf_access_arbiter.sv
// Serialises two requesters onto one register file's WrEn/RdEn command port.
// Define RF_ARB_FIXED_PRIO_EN to make r0 win every tie (no round-robin pointer).
module rf_access_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int RF_AW = RF_AW_DEF
) (
    input  logic             CLK,
    input  logic             RST,

    input  logic             r0_req,
    input  logic             r0_wr,
    input  logic [AW-1:0]    r0_addr,
    input  logic [DW-1:0]    r0_wdata,
    output logic             r0_gnt,
    output logic             r0_rvalid,
    output logic [DW-1:0]    r0_rdata,

    input  logic             r1_req,
    input  logic             r1_wr,
    input  logic [AW-1:0]    r1_addr,
    input  logic [DW-1:0]    r1_wdata,
    output logic             r1_gnt,
    output logic             r1_rvalid,
    output logic [DW-1:0]    r1_rdata,

    output logic             rf_wr_en,
    output logic             rf_rd_en,
    output logic [RF_AW-1:0] rf_address,
    output logic [DW-1:0]    rf_wr_data,
    input  logic [DW-1:0]    rf_rd_data,

    output logic             busy
);

    localparam int PAD = RF_AW - AW;

    arb_state_e       state_q;
    logic             win_q;
    logic             r0_gnt_q;
    logic             r1_gnt_q;
    logic             r0_rvalid_q;
    logic             r1_rvalid_q;
    logic [DW-1:0]    r0_rdata_q;
    logic [DW-1:0]    r1_rdata_q;
    logic             wr_en_q;
    logic             rd_en_q;
    logic [RF_AW-1:0] addr_q;
    logic [DW-1:0]    wdata_q;
    logic             busy_q;

    logic [1:0]       req_s;
    logic [1:0]       pick_s;
    logic             win_s;
    logic             sel_wr_s;
    logic [AW-1:0]    sel_addr_s;
    logic [DW-1:0]    sel_wdata_s;

    assign req_s = {r1_req, r0_req};

`ifdef RF_ARB_FIXED_PRIO_EN
    // r0 takes every tie, so r1 is served only when r0 is quiet.
    always_comb begin
        pick_s = 2'b00;
        if (req_s[0]) begin
            pick_s = 2'b01;
        end else if (req_s[1]) begin
            pick_s = 2'b10;
        end else begin
            pick_s = 2'b00;
        end
    end
`else
    logic ptr_q;
    logic ptr_next_s;

    rr_arbiter_2 u_rr (
        .req_i      (req_s),
        .ptr_i      (ptr_q),
        .advance_i  (state_q == IDLE),
        .gnt_o      (pick_s),
        .ptr_next_o (ptr_next_s)
    );

    // Pointer only moves when a request is actually latched in IDLE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr_q <= REQ0;
        end else if (state_q == IDLE) begin
            ptr_q <= ptr_next_s;
        end else begin
            ptr_q <= ptr_q;
        end
    end
`endif

    assign win_s       = pick_s[1];
    assign sel_wr_s    = win_s ? r1_wr    : r0_wr;
    assign sel_addr_s  = win_s ? r1_addr  : r0_addr;
    assign sel_wdata_s = win_s ? r1_wdata : r0_wdata;

    // Access FSM: strobes default low each cycle, address/data hold between commands.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            win_q       <= REQ0;
            r0_gnt_q    <= 1'b0;
            r1_gnt_q    <= 1'b0;
            r0_rvalid_q <= 1'b0;
            r1_rvalid_q <= 1'b0;
            r0_rdata_q  <= '0;
            r1_rdata_q  <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            r0_gnt_q    <= 1'b0;
            r1_gnt_q    <= 1'b0;
            r0_rvalid_q <= 1'b0;
            r1_rvalid_q <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_s != 2'b00) begin
                        state_q  <= ISSUE;
                        busy_q   <= 1'b1;
                        win_q    <= win_s;
                        wr_en_q  <= sel_wr_s;
                        rd_en_q  <= ~sel_wr_s;
                        addr_q   <= {{PAD{1'b0}}, sel_addr_s};
                        wdata_q  <= sel_wdata_s;
                        r0_gnt_q <= ~win_s;
                        r1_gnt_q <= win_s;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ISSUE: begin
                    // wr_en_q is still high here only for a write command.
                    if (wr_en_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= RDWAIT;
                        busy_q  <= 1'b1;
                    end
                end
                RDWAIT: begin
                    state_q <= RESP;
                    busy_q  <= 1'b1;
                    if (win_q == REQ1) begin
                        r1_rdata_q  <= rf_rd_data;
                        r1_rvalid_q <= 1'b1;
                    end else begin
                        r0_rdata_q  <= rf_rd_data;
                        r0_rvalid_q <= 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign r0_gnt     = r0_gnt_q;
    assign r1_gnt     = r1_gnt_q;
    assign r0_rvalid  = r0_rvalid_q;
    assign r1_rvalid  = r1_rvalid_q;
    assign r0_rdata   = r0_rdata_q;
    assign r1_rdata   = r1_rdata_q;
    assign rf_wr_en   = wr_en_q;
    assign rf_rd_en   = rd_en_q;
    assign rf_address = addr_q;
    assign rf_wr_data = wdata_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Bench for rf_access_arbiter: register-file model plus a transaction-level arbiter model.
`timescale 1ns/1ps
module tb_rf_access_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        r0_req, r0_wr, r1_req, r1_wr;
    logic [2:0]  r0_addr, r1_addr;
    logic [15:0] r0_wdata, r1_wdata;
    logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [15:0] r0_rdata, r1_rdata;
    logic        rf_wr_en, rf_rd_en, busy;
    logic [7:0]  rf_address;
    logic [15:0] rf_wr_data, rf_rd_data;
    logic        fm_init;

    rf_access_arbiter dut (
        .CLK(CLK), .RST(RST),
        .r0_req(r0_req), .r0_wr(r0_wr), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_wr(r1_wr), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_address(rf_address),
        .rf_wr_data(rf_wr_data), .rf_rd_data(rf_rd_data), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Register file: synchronous write, registered read data.
    logic [15:0] fmem [0:7];
    always @(posedge CLK) begin
        if (fm_init) begin
            for (int i = 0; i < 8; i++) fmem[i] <= 16'h1000 + 16'(i);
        end else begin
            if (rf_wr_en) fmem[rf_address[2:0]] <= rf_wr_data;
            if (rf_rd_en) rf_rd_data <= fmem[rf_address[2:0]];
        end
    end

    int n_checks, n_fail, cyc;
    logic [15:0] ref_mem [0:7];
    logic [15:0] last_rdata [0:1];
    int idle_from, busy_from, t_gcyc, wr_pulses, n0;
    bit ptr_m, t_valid, t_id, t_wr;
    logic [2:0]  t_addr;
    logic [15:0] t_wdata, t_rdata;
    int gnt_id_log[$];
    int gnt_cyc_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        t_valid = 1'b0;
        ptr_m = 1'b0;
        idle_from = cyc;
        busy_from = cyc;
        last_rdata[0] = 16'h0;
        last_rdata[1] = 16'h0;
    endtask

    // Transaction-level arbiter: decides who is served next from the current request lines.
    task automatic model_sample();
        bit w;
        if (cyc >= idle_from && (r0_req || r1_req)) begin
            if (r0_req && r1_req) begin
`ifdef RF_ARB_FIXED_PRIO_EN
                w = 1'b0;
`else
                w = ptr_m;
`endif
            end else begin
                w = r1_req;
            end
            ptr_m = !w;
            t_valid = 1'b1;
            t_id = w;
            t_wr = w ? r1_wr : r0_wr;
            t_addr = w ? r1_addr : r0_addr;
            t_wdata = w ? r1_wdata : r0_wdata;
            t_gcyc = cyc + 1;
            busy_from = cyc + 1;
            idle_from = t_wr ? cyc + 2 : cyc + 4;
            if (t_wr) ref_mem[t_addr] = t_wdata;
            else t_rdata = ref_mem[t_addr];
        end
    endtask

    task automatic check_outputs();
        bit at_g, at_rv;
        at_g  = t_valid && cyc == t_gcyc;
        at_rv = t_valid && !t_wr && cyc == t_gcyc + 2;
        if (at_rv) last_rdata[t_id] = t_rdata;
        if (r0_gnt) begin gnt_id_log.push_back(0); gnt_cyc_log.push_back(cyc); end
        if (r1_gnt) begin gnt_id_log.push_back(1); gnt_cyc_log.push_back(cyc); end
        if (rf_wr_en) wr_pulses++;
        chk("r0_gnt", 32'(r0_gnt), 32'(at_g && !t_id));
        chk("r1_gnt", 32'(r1_gnt), 32'(at_g && t_id));
        chk("r0_rvalid", 32'(r0_rvalid), 32'(at_rv && !t_id));
        chk("r1_rvalid", 32'(r1_rvalid), 32'(at_rv && t_id));
        chk("r0_rdata", 32'(r0_rdata), 32'(last_rdata[0]));
        chk("r1_rdata", 32'(r1_rdata), 32'(last_rdata[1]));
        chk("rf_wr_en", 32'(rf_wr_en), 32'(at_g && t_wr));
        chk("rf_rd_en", 32'(rf_rd_en), 32'(at_g && !t_wr));
        chk("busy", 32'(busy), 32'(cyc >= busy_from && cyc < idle_from));
        chk("en_exclusive", 32'(rf_wr_en & rf_rd_en), 32'd0);
        chk("gnt_onehot", 32'(r0_gnt & r1_gnt), 32'd0);
        chk("rvalid_onehot", 32'(r0_rvalid & r1_rvalid), 32'd0);
        if (at_g) begin
            chk("rf_address", 32'(rf_address), 32'({5'b0, t_addr}));
            if (t_wr) chk("rf_wr_data", 32'(rf_wr_data), 32'(t_wdata));
        end
    endtask

    task automatic tick();
        if (!RST) model_sample();
        @(negedge CLK);
        cyc++;
        if (RST) model_reset();
        check_outputs();
        if (t_valid && cyc == t_gcyc) begin
            if (t_id) r1_req = 1'b0;
            else r0_req = 1'b0;
        end
    endtask

    task automatic raise_req(input bit id, input bit wr);
        if (id) begin
            r1_req = 1'b1; r1_wr = wr;
            r1_addr = 3'($urandom_range(0, 7)); r1_wdata = 16'($urandom);
        end else begin
            r0_req = 1'b1; r0_wr = wr;
            r0_addr = 3'($urandom_range(0, 7)); r0_wdata = 16'($urandom);
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; wr_pulses = 0;
        RST = 1'b1; fm_init = 1'b1;
        r0_req = 1'b0; r0_wr = 1'b0; r0_addr = 3'd0; r0_wdata = 16'h0;
        r1_req = 1'b0; r1_wr = 1'b0; r1_addr = 3'd0; r1_wdata = 16'h0;
        for (int i = 0; i < 8; i++) ref_mem[i] = 16'h1000 + 16'(i);
        model_reset();
        repeat (3) tick();
        chk("rst_rf_address", 32'(rf_address), 32'd0);
        chk("rst_rf_wr_data", 32'(rf_wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        RST = 1'b0; fm_init = 1'b0;
        tick();

        // r0 writes A5A5 to entry 3, then r1 reads it back.
        r0_req = 1'b1; r0_wr = 1'b1; r0_addr = 3'd3; r0_wdata = 16'hA5A5;
        tick();
        chk("d1_r0_gnt", 32'(r0_gnt), 32'd1);
        tick();
        n0 = cyc;
        r1_req = 1'b1; r1_wr = 1'b0; r1_addr = 3'd3; r1_wdata = 16'h0;
        tick();
        chk("d1_r1_gnt_n1", 32'(r1_gnt), 32'd1);
        chk("d1_gnt_latency", 32'(cyc - n0), 32'd1);
        tick(); tick();
        chk("d1_r1_rvalid_n3", 32'(r1_rvalid), 32'd1);
        chk("d1_r1_rdata", 32'(r1_rdata), 32'h0000A5A5);
        tick();

        // Reset lands while a read sits in RDWAIT.
        r0_req = 1'b1; r0_wr = 1'b0; r0_addr = 3'd5; r0_wdata = 16'h0;
        tick();
        chk("d4_r0_gnt", 32'(r0_gnt), 32'd1);
        tick();
        RST = 1'b1; r0_req = 1'b0;
        tick();
        chk("d4_rst_rvalid", 32'(r0_rvalid), 32'd0);
        chk("d4_rst_rdata", 32'(r0_rdata), 32'd0);
        chk("d4_rst_rd_en", 32'(rf_rd_en), 32'd0);
        chk("d4_rst_busy", 32'(busy), 32'd0);
        RST = 1'b0;
        tick();
        r0_req = 1'b1; r0_wr = 1'b0; r0_addr = 3'd0;
        tick();
        chk("d4_r0_gnt_after", 32'(r0_gnt), 32'd1);
        tick(); tick();
        chk("d4_r0_rvalid", 32'(r0_rvalid), 32'd1);
        chk("d4_r0_rdata", 32'(r0_rdata), 32'h00001000);
        tick();

        // Both request continuously right after reset.
        RST = 1'b1; tick(); tick(); RST = 1'b0;
        gnt_id_log.delete(); gnt_cyc_log.delete();
        raise_req(1'b0, 1'($urandom_range(0, 1)));
        raise_req(1'b1, 1'($urandom_range(0, 1)));
        for (int k = 0; k < 200 && gnt_id_log.size() < 20; k++) begin
            tick();
            if (!r0_req) raise_req(1'b0, 1'($urandom_range(0, 1)));
            if (!r1_req) raise_req(1'b1, 1'($urandom_range(0, 1)));
        end
        chk("alt_count", 32'(gnt_id_log.size() >= 20), 32'd1);
        for (int i = 0; i < gnt_id_log.size() && i < 20; i++) begin
`ifdef RF_ARB_FIXED_PRIO_EN
            chk("fixed_order", 32'(gnt_id_log[i]), 32'd0);
`else
            chk("alt_order", 32'(gnt_id_log[i]), 32'(i % 2));
`endif
        end

        // r1 alone, reading back to back.
        r0_req = 1'b0; r1_req = 1'b0;
        repeat (4) tick();
        gnt_id_log.delete(); gnt_cyc_log.delete(); wr_pulses = 0;
        raise_req(1'b1, 1'b0);
        for (int k = 0; k < 30; k++) begin
            tick();
            if (!r1_req) raise_req(1'b1, 1'b0);
        end
        chk("r1_grant_count", 32'(gnt_cyc_log.size() >= 5), 32'd1);
        for (int i = 1; i < gnt_cyc_log.size(); i++) begin
            chk("r1_spacing", 32'(gnt_cyc_log[i] - gnt_cyc_log[i-1]), 32'd4);
            chk("r1_only", 32'(gnt_id_log[i]), 32'd1);
        end
        chk("r1_no_wr_en", 32'(wr_pulses), 32'd0);

        // Random traffic, including requests withdrawn before being sampled.
        r1_req = 1'b0;
        tick();
        for (int k = 0; k < 400; k++) begin
            if (!r0_req) begin
                if ($urandom_range(0, 2) == 0) raise_req(1'b0, 1'($urandom_range(0, 1)));
            end else if ($urandom_range(0, 15) == 0) begin
                r0_req = 1'b0;
            end
            if (!r1_req) begin
                if ($urandom_range(0, 2) == 0) raise_req(1'b1, 1'($urandom_range(0, 1)));
            end else if ($urandom_range(0, 15) == 0) begin
                r1_req = 1'b0;
            end
            tick();
        end
        r0_req = 1'b0; r1_req = 1'b0;
        repeat (6) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
